// File: rtl/dct_mac_unit.sv
// Three-stage multiply-accumulate for the 8x8 forward DCT: level shift, two cosine
// products, and a 64-term accumulator that emits one rounded, saturated F(u,v).
module dct_mac_unit (
   input  logic               clk,
   input  logic               rst_in,
   input  logic               rst_acc,
   input  logic               act_mac,
   input  logic [2:0]         u,
   input  logic [2:0]         v,
   input  logic [2:0]         x,
   input  logic [2:0]         y,
   input  logic [7:0]         pixel_in,
   output logic signed [11:0] coef_out,
   output logic [5:0]         coef_addr,
   output logic               coef_valid,
   output logic               sat_flag,
   output logic               busy
);

   // T[k][n] = round(2048*a(k)*cos((2n+1)k*pi/16)), folded onto one quarter-wave table
   function automatic logic signed [11:0] cos_rom(input logic [2:0] k, input logic [2:0] n);
      logic [4:0]         m;
      logic [3:0]         f;
      logic               neg;
      logic signed [11:0] mag;
      m   = 5'({n, 1'b1}) * 5'(k);
      f   = 4'd0;
      neg = 1'b0;
      if (m <= 5'd8) begin
         f = 4'(m);
      end else if (m <= 5'd16) begin
         f   = 4'(5'd16 - m);
         neg = 1'b1;
      end else if (m <= 5'd24) begin
         f   = 4'(m - 5'd16);
         neg = 1'b1;
      end else begin
         f = 4'(6'd32 - {1'b0, m});
      end
      case (f)
         4'd0:    mag = 12'sd1024;
         4'd1:    mag = 12'sd1004;
         4'd2:    mag = 12'sd946;
         4'd3:    mag = 12'sd851;
         4'd4:    mag = 12'sd724;
         4'd5:    mag = 12'sd569;
         4'd6:    mag = 12'sd392;
         4'd7:    mag = 12'sd200;
         default: mag = 12'sd0;
      endcase
      if (k == 3'd0) return 12'sd724;
      return neg ? -mag : mag;
   endfunction

   logic               s1_vld_q, s1_vld_d;
   logic signed [8:0]  d_s1_q, d_s1_d;
   logic [2:0]         u_s1_q, u_s1_d, v_s1_q, v_s1_d, x_s1_q, x_s1_d, y_s1_q, y_s1_d;
   logic               s2_vld_q, s2_vld_d;
   logic signed [20:0] p_s2_q, p_s2_d;
   logic signed [11:0] tv_s2_q, tv_s2_d;
   logic [2:0]         u_s2_q, u_s2_d, v_s2_q, v_s2_d;
   logic signed [39:0] acc_q, acc_d;
   logic [5:0]         cnt_q, cnt_d;
   logic signed [11:0] coef_q, coef_d;
   logic [5:0]         addr_q, addr_d;
   logic               valid_q, valid_d;
   logic               sat_q, sat_d;

   logic signed [11:0] tu;
   logic signed [11:0] tv;
   logic signed [20:0] p1;
   logic signed [32:0] term;
   logic signed [39:0] sum;
   logic signed [39:0] rnd;

   always_comb begin
      tu   = cos_rom(u_s1_q, x_s1_q);
      tv   = cos_rom(v_s1_q, y_s1_q);
      p1   = 21'(d_s1_q) * 21'(tu);
      term = 33'(p_s2_q) * 33'(tv_s2_q);
      sum  = acc_q + 40'(term);
      rnd  = (sum + 40'sd2097152) >>> 22;

      s1_vld_d = s1_vld_q;
      d_s1_d   = d_s1_q;
      u_s1_d   = u_s1_q;
      v_s1_d   = v_s1_q;
      x_s1_d   = x_s1_q;
      y_s1_d   = y_s1_q;
      s2_vld_d = s2_vld_q;
      p_s2_d   = p_s2_q;
      tv_s2_d  = tv_s2_q;
      u_s2_d   = u_s2_q;
      v_s2_d   = v_s2_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      coef_d   = coef_q;
      addr_d   = addr_q;
      valid_d  = 1'b0;
      sat_d    = sat_q;

      if (rst_acc) begin
         // flushes in-flight terms; result registers and sticky flag are kept
         s1_vld_d = 1'b0;
         s2_vld_d = 1'b0;
         acc_d    = '0;
         cnt_d    = '0;
      end else begin
         s1_vld_d = act_mac;
         if (act_mac) begin
            d_s1_d = $signed({1'b0, pixel_in}) - 9'sd128;
            u_s1_d = u;
            v_s1_d = v;
            x_s1_d = x;
            y_s1_d = y;
         end
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            p_s2_d  = p1;
            tv_s2_d = tv;
            u_s2_d  = u_s1_q;
            v_s2_d  = v_s1_q;
         end
         if (s2_vld_q) begin
            if (cnt_q == 6'd63) begin
               valid_d = 1'b1;
               addr_d  = {v_s2_q, u_s2_q};
               acc_d   = '0;
               cnt_d   = '0;
               if (rnd > 40'sd2047) begin
                  coef_d = 12'sd2047;
                  sat_d  = 1'b1;
               end else if (rnd < -40'sd2048) begin
                  coef_d = -12'sd2048;
                  sat_d  = 1'b1;
               end else begin
                  coef_d = rnd[11:0];
               end
            end else begin
               acc_d = sum;
               cnt_d = cnt_q + 6'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         s1_vld_q <= 1'b0;
         d_s1_q   <= '0;
         u_s1_q   <= '0;
         v_s1_q   <= '0;
         x_s1_q   <= '0;
         y_s1_q   <= '0;
         s2_vld_q <= 1'b0;
         p_s2_q   <= '0;
         tv_s2_q  <= '0;
         u_s2_q   <= '0;
         v_s2_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         coef_q   <= '0;
         addr_q   <= '0;
         valid_q  <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         s1_vld_q <= s1_vld_d;
         d_s1_q   <= d_s1_d;
         u_s1_q   <= u_s1_d;
         v_s1_q   <= v_s1_d;
         x_s1_q   <= x_s1_d;
         y_s1_q   <= y_s1_d;
         s2_vld_q <= s2_vld_d;
         p_s2_q   <= p_s2_d;
         tv_s2_q  <= tv_s2_d;
         u_s2_q   <= u_s2_d;
         v_s2_q   <= v_s2_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         coef_q   <= coef_d;
         addr_q   <= addr_d;
         valid_q  <= valid_d;
         sat_q    <= sat_d;
      end
   end

   assign coef_out   = coef_q;
   assign coef_addr  = addr_q;
   assign coef_valid = valid_q;
   assign sat_flag   = sat_q;
   assign busy       = s1_vld_q | s2_vld_q | (cnt_q != 6'd0);

endmodule

// File: doc/dct_mac_unit.md
# dct_mac_unit

Arithmetic datapath directly downstream of the DCT control FSM in the MPEG transform path. Each cycle `act_mac` is high, it consumes one pixel from the image memory together with the FSM's `u`, `v`, `x`, `y` indices. It multiplies the level-shifted pixel by two entries of an internal cosine ROM and accumulates the products. After 64 terms it emits one rounded, saturated 2D-DCT coefficient F(u,v) with its block address.

## Interface
- No parameters; all widths fixed.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `rst_acc`  in  1  synchronous clear from the FSM's `rst_out`.
- `act_mac`  in  1  term strobe; sample inputs this edge.
- `u`, `v`, `x`, `y`  in  3 each  frequency and spatial indices from the FSM.
- `pixel_in`  in  8  unsigned pixel from image memory; valid whenever `act_mac` is high.
- `coef_out`  out  12  signed coefficient F(u,v), two's complement.
- `coef_addr`  out  6  coefficient address, v*8+u.
- `coef_valid`  out  1  one-cycle pulse; `coef_out` and `coef_addr` are valid.
- `sat_flag`  out  1  sticky; set when any coefficient saturated.
- `busy`  out  1  high while any pipeline stage is valid or the term count is nonzero.

## Operation
- Cosine ROM T[k][n], k,n in 0..7: signed 12-bit, T = round(2048·a(k)·cos((2n+1)kπ/16)).
  - a(0) = √(1/8), so T[0][n] = 724.
  - a(k>0) = 1/2.
  - Constant table, combinational read.
- Stage 1, on an edge with `act_mac`=1:
  - d = pixel_in − 128, signed 9-bit.
  - Register d, u, v, x, y; set v1=1.
- Stage 2, on an edge with v1=1:
  - p1 = d·T[u][x], signed 21-bit.
  - Register p1, T[v][y], u, v; set v2=1.
- Stage 3, on an edge with v2=1:
  - term = p1·T[v][y], signed 33-bit.
  - Accumulator is signed 40-bit.
  - If term count < 63: acc += term, count++.
  - If term count = 63 (64th term): s = acc + term; `coef_out` ← sat12((s + 2^21) >>> 22).
    - `coef_addr` ← {v,u} of that term; `coef_valid` ← 1.
    - acc ← 0, count ← 0.
- Saturation range: [−2048, 2047]. When clamping, also set `sat_flag`.
- `coef_valid` is cleared on every edge that does not complete a coefficient.
- `rst_acc`=1 takes priority over all datapath updates:
  - Clears acc, count, v1, v2; terms in flight are discarded.
  - Does not alter `coef_out`, `coef_addr` or `sat_flag`.
  - `coef_valid` still follows the one-cycle rule: it drops on a `rst_acc` edge.
- `act_mac` on every consecutive cycle is supported: one term per cycle, no stalls.
- Index wrap-around is the FSM's concern; this block accumulates exactly 64 terms per coefficient regardless of index order.

## Timing
- `rst_in` asserted, asynchronously, sets these to 0: all outputs, acc, count, v1, v2 and all pipeline registers. `sat_flag` clears only on `rst_in`.
- Pixel memory is read by the FSM with `rd_en` at least one cycle before `act_mac`, so `pixel_in` is stable at the sampling edge. No data is registered from `rd_en` in this block.
- Latency: 64th term sampled at edge E0 → `coef_valid` high from E2 to E3.
- Next coefficient's first term may be sampled at E1; it reaches the accumulator at E3 with acc already cleared.
- `rst_acc` on the same edge as a 64th-term accumulate: the clear wins and no `coef_valid` is produced.
- `act_mac` while `rst_acc`=1: the term is dropped.
- `rst_in` mid-block: the partial sum is lost and the next 64 terms start a new coefficient.

## Test plan
- All 64 pixels = 128, FSM order u,v outer, x,y inner → 64 `coef_valid` pulses, every `coef_out` = 0, addresses 0..63 in order, `sat_flag` = 0.
- All pixels = 255 → F(0,0) = 1016, all 63 AC coefficients = 0.
- All pixels = 0 → F(0,0) = −1024, AC = 0.
- Pixel = 255 only at (x,y) = (0,0), else 128 → F(0,0) = round(127·724·724/2^22) = 16; F(1,0) = round(127·1004·724/2^22) = 22 (T[1][0] = 1004).
- Back-to-back `act_mac` for 64 cycles starting at edge 10 → `coef_valid` exactly at edge 75 (E0 = 73), `busy` low from edge 75.
- `rst_acc` pulse after 30 terms, then 64 pixels = 255 → single `coef_out` = 1016. Also check `rst_acc` coinciding with the 64th-term accumulate edge → no pulse.
